fpnew_divsqrt_multi_ctrl: RTL
=============================

FPNEW_DIVSQRT_MULTI_CTRL -- requirements
Module: fpnew_divsqrt_multi_ctrl

Interface
REQ-001 SHALL take parameter NumPipeRegs, default 0: total external pipeline stages in the controlled div/sqrt datapath.
REQ-002 SHALL take parameter PipeConfig, default fpnew_pkg::AFTER; split as NUM_INP = NumPipeRegs (BEFORE), NumPipeRegs/2 (DISTRIBUTED), else 0; NUM_OUT = NumPipeRegs - NUM_INP.
REQ-003 SHALL take parameter TagWidth, default 1: width of the tag carried alongside each operation.
REQ-004 SHALL take parameter ArmDelay, default 2: cycles after start during which unit_ready_i is ignored.
REQ-005 SHALL have ports: clk_i in 1, clock; rst_ni in 1, asynchronous active-low reset.
REQ-006 SHALL have ports: in_valid_i in 1, operation offered; in_ready_o out 1, operation accepted; in_tag_i in TagWidth, operation tag.
REQ-007 SHALL have ports: out_valid_o out 1, result valid; out_ready_i in 1, downstream accepts; out_tag_o out TagWidth, result tag.
REQ-008 SHALL have ports: flush_i in 1, kill all in-flight operations; busy_o out 1, any operation in flight.
REQ-009 SHALL have ports: reg_enable_o out max(NumPipeRegs,1), per-stage datapath register enables (inputs first, then outputs); fsm_start_o out 1, issue to unit; unit_ready_i in 1, unit not busy.

Function
REQ-010 SHALL track NUM_INP input stages as valid/tag registers; stage i loads when its upstream is valid and it is empty or draining; reg_enable_o[i] SHALL equal that load condition.
REQ-011 SHALL assert in_ready_o when input stage 0 can load (or, for NUM_INP=0, when the FSM can start); an operation transfers on in_valid_i & in_ready_o.
REQ-012 SHALL implement FSM states IDLE, BUSY, HOLD; reset state IDLE.
REQ-013 SHALL assert fsm_start_o combinationally in IDLE when the last input stage (or input port) is valid and unit_ready_i=1, for exactly one cycle per operation; tag captured on that edge; IDLE->BUSY.
REQ-014 In BUSY, SHALL count ArmDelay cycles, then declare done on the first cycle with unit_ready_i=1.
REQ-015 On done, SHALL offer the result to output stage 0 (or out_valid_o if NUM_OUT=0); if accepted same cycle, BUSY->IDLE, else BUSY->HOLD.
REQ-016 In HOLD, SHALL keep offering the result with the captured tag; on acceptance HOLD->IDLE.
REQ-017 SHALL track NUM_OUT output stages as valid/tag registers with the same load rule; reg_enable_o[NUM_INP+i] SHALL equal stage i load condition.
REQ-018 SHALL keep each stage's valid/tag stable while valid and not drained (no data loss under backpressure).
REQ-019 SHALL allow a new start no earlier than the cycle after returning to IDLE; at most one operation in the unit.
REQ-020 SHALL assert busy_o whenever any stage valid bit is set or FSM is not IDLE.
REQ-021 flush_i SHALL clear all valid bits and force FSM to IDLE at the next edge; fsm_start_o and reg_enable_o SHALL be 0 in the flush cycle; in_ready_o SHALL be 0 while flush_i=1.
REQ-022 If done and flush_i coincide, flush SHALL win; no result emitted.
REQ-023 SHALL tie reg_enable_o to 0 when NumPipeRegs=0.

Reset
REQ-024 While rst_ni=0: FSM IDLE, all valid bits 0, tags 0, ArmDelay counter 0.
REQ-025 Reset outputs: in_ready_o per REQ-011 with empty pipeline, out_valid_o=0, out_tag_o=0, fsm_start_o=0, reg_enable_o=0, busy_o=0.
REQ-026 Reset asserted mid-operation SHALL discard the operation with no result after deassertion.

Verification
REQ-027 NumPipeRegs=0, out_ready_i=1: tag 0x1 at cycle 0, unit_ready_i low cycles 1-9 -> fsm_start_o cycle 0, out_valid_o=1 tag 0x1 at cycle 10 only.
REQ-028 Same, out_ready_i=0 cycles 10-14 -> HOLD, out_valid_o and tag stable cycles 10-15, transfer cycle 15, in_ready_o=0 until cycle 16.
REQ-029 NumPipeRegs=2 DISTRIBUTED: reg_enable_o[0] on input acceptance, fsm_start_o one cycle later, reg_enable_o[1] on done, out_valid_o one cycle after done.
REQ-030 Back-to-back tags 0x0,0x1 offered continuously -> two starts, separated by >= ArmDelay+2 cycles, results in order, no duplicates.
REQ-031 flush_i pulsed in BUSY cycle 5 -> busy_o=0 at cycle 6, no out_valid_o for that tag, next operation completes normally.
REQ-032 rst_ni low at cycle 4 of an operation -> all outputs at reset values; first post-reset operation completes with correct tag.

Source files
------------

// File: rtl/fpnew_divsqrt_multi_ctrl.sv
// rtl/fpnew_divsqrt_multi_ctrl.sv - handshake, pipeline-stage and issue control for a multi-cycle div/sqrt unit
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_valid_i/in_ready_o    operation handshake, in_tag_i carried with it
//   out_valid_o/out_ready_i  result handshake, out_tag_o carried with it
//   flush_i                  kill everything in flight; busy_o = anything in flight
//   reg_enable_o             datapath register enables (input stages, then output stages)
//   fsm_start_o/unit_ready_i issue strobe to the iterative unit / unit idle indication

package fpnew_pkg;
  typedef enum logic [1:0] {BEFORE, AFTER, INSIDE, DISTRIBUTED} pipe_config_t;
endpackage

module fpnew_divsqrt_multi_ctrl #(
  parameter int unsigned             NumPipeRegs = 0,
  parameter fpnew_pkg::pipe_config_t PipeConfig  = fpnew_pkg::AFTER,
  parameter int unsigned             TagWidth    = 1,
  parameter int unsigned             ArmDelay    = 2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         in_valid_i,
  output logic                                         in_ready_o,
  input  logic [TagWidth-1:0]                          in_tag_i,
  output logic                                         out_valid_o,
  input  logic                                         out_ready_i,
  output logic [TagWidth-1:0]                          out_tag_o,
  input  logic                                         flush_i,
  output logic                                         busy_o,
  output logic [((NumPipeRegs > 0) ? NumPipeRegs : 1)-1:0] reg_enable_o,
  output logic                                         fsm_start_o,
  input  logic                                         unit_ready_i
);

  localparam int unsigned NUM_INP = (PipeConfig == fpnew_pkg::BEFORE)      ? NumPipeRegs :
                                    (PipeConfig == fpnew_pkg::DISTRIBUTED) ? NumPipeRegs / 2 : 0;
  localparam int unsigned NUM_OUT = NumPipeRegs - NUM_INP;
  localparam int unsigned CNT_W   = (ArmDelay > 0) ? $clog2(ArmDelay + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [TagWidth-1:0] tag_q;

  logic                fsm_in_valid, fsm_in_ready;
  logic [TagWidth-1:0] fsm_in_tag;
  logic                fsm_out_valid, fsm_out_ready;
  logic                done, armed;
  logic                inp_busy, out_busy;

  // The unit reports ready for a few cycles after start before it has
  // actually picked up the operation, so completion is only believed once armed.
  assign armed         = (cnt_q == CNT_W'(ArmDelay));
  assign fsm_in_ready  = (state_q == IDLE) & unit_ready_i & ~flush_i;
  assign fsm_start_o   = fsm_in_ready & fsm_in_valid;
  assign done          = (state_q == BUSY) & armed & unit_ready_i & ~flush_i;
  assign fsm_out_valid = done | ((state_q == HOLD) & ~flush_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (fsm_start_o) begin
          state_q <= BUSY;
          cnt_q   <= '0;
          tag_q   <= fsm_in_tag;
        end
        BUSY: begin
          if (done)        state_q <= fsm_out_ready ? IDLE : HOLD;
          else if (!armed) cnt_q   <= cnt_q + CNT_W'(1);
        end
        HOLD: if (fsm_out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  if (NumPipeRegs == 0) begin : g_no_en
    assign reg_enable_o = '0;
  end

  // Input stages: a stage loads when upstream is valid and it is empty or draining.
  if (NUM_INP > 0) begin : g_inp
    logic [NUM_INP-1:0] v_all;
    for (genvar i = 0; i < NUM_INP; i++) begin : g_stage
      logic                v_q, rdy, ld, up_v, dn_r;
      logic [TagWidth-1:0] t_q, up_t;
      if (i == 0) begin : g_first
        assign up_v = in_valid_i;
        assign up_t = in_tag_i;
      end else begin : g_chain
        assign up_v = g_stage[i-1].v_q;
        assign up_t = g_stage[i-1].t_q;
      end
      if (i == NUM_INP - 1) begin : g_last
        assign dn_r = fsm_in_ready;
      end else begin : g_mid
        assign dn_r = g_stage[i+1].rdy;
      end
      assign rdy             = (~v_q | dn_r) & ~flush_i;
      assign ld              = up_v & rdy;
      assign reg_enable_o[i] = ld;
      assign v_all[i]        = v_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= 1'b0;
          t_q <= '0;
        end else if (flush_i) begin
          v_q <= 1'b0;
        end else if (rdy) begin
          v_q <= up_v;
          if (up_v) t_q <= up_t;
        end
      end
    end
    assign in_ready_o   = g_stage[0].rdy;
    assign fsm_in_valid = g_stage[NUM_INP-1].v_q;
    assign fsm_in_tag   = g_stage[NUM_INP-1].t_q;
    assign inp_busy     = |v_all;
  end else begin : g_no_inp
    assign in_ready_o   = fsm_in_ready;
    assign fsm_in_valid = in_valid_i;
    assign fsm_in_tag   = in_tag_i;
    assign inp_busy     = 1'b0;
  end

  // Output stages: same load rule, fed by the FSM result offer.
  if (NUM_OUT > 0) begin : g_out
    logic [NUM_OUT-1:0] v_all;
    for (genvar i = 0; i < NUM_OUT; i++) begin : g_stage
      logic                v_q, rdy, ld, up_v, dn_r;
      logic [TagWidth-1:0] t_q, up_t;
      if (i == 0) begin : g_first
        assign up_v = fsm_out_valid;
        assign up_t = tag_q;
      end else begin : g_chain
        assign up_v = g_stage[i-1].v_q;
        assign up_t = g_stage[i-1].t_q;
      end
      if (i == NUM_OUT - 1) begin : g_last
        assign dn_r = out_ready_i;
      end else begin : g_mid
        assign dn_r = g_stage[i+1].rdy;
      end
      assign rdy                       = (~v_q | dn_r) & ~flush_i;
      assign ld                        = up_v & rdy;
      assign reg_enable_o[NUM_INP + i] = ld;
      assign v_all[i]                  = v_q;
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v_q <= 1'b0;
          t_q <= '0;
        end else if (flush_i) begin
          v_q <= 1'b0;
        end else if (rdy) begin
          v_q <= up_v;
          if (up_v) t_q <= up_t;
        end
      end
    end
    assign fsm_out_ready = g_stage[0].rdy;
    assign out_valid_o   = g_stage[NUM_OUT-1].v_q;
    assign out_tag_o     = g_stage[NUM_OUT-1].t_q;
    assign out_busy      = |v_all;
  end else begin : g_no_out
    assign fsm_out_ready = out_ready_i;
    assign out_valid_o   = fsm_out_valid;
    assign out_tag_o     = tag_q;
    assign out_busy      = 1'b0;
  end

  assign busy_o = inp_busy | out_busy | (state_q != IDLE);

endmodule
